// File: rtl/cell_scan_sequencer.sv
// Raster-order cell scan controller: fetch cell, issue op, wait result, write pixel.
// Optional abort input is compiled in when CELL_SEQ_ABORT_EN is defined.
module cell_scan_sequencer #(
  parameter  int IMG_W  = 640,
  parameter  int IMG_H  = 480,
  parameter  int CELL_N = 3,
  localparam int OUT_W  = IMG_W - CELL_N + 1,
  localparam int OUT_H  = IMG_H - CELL_N + 1,
  localparam int XW     = $clog2(IMG_W),
  localparam int YW     = $clog2(IMG_H),
  localparam int AW     = $clog2(OUT_W * OUT_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    opcode_in,
  input  logic [7:0]    user_in,
`ifdef CELL_SEQ_ABORT_EN
  input  logic          abort,
`endif
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          fetch_req,
  output logic [XW-1:0] fetch_x,
  output logic [YW-1:0] fetch_y,
  input  logic          fetch_ack,
  output logic          proc_valid,
  input  logic          proc_ready,
  output logic [3:0]    proc_opcode,
  output logic [7:0]    proc_user,
  input  logic          res_valid,
  input  logic [23:0]   res_pixel,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [23:0]   wr_data
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_e;

  localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);
  localparam logic [3:0]    OP_MAX = 4'd11;

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    opc_q, opc_d;
  logic [7:0]    usr_q, usr_d;
  logic [23:0]   data_q, data_d;
  logic          err_q, err_d;
  logic          fetch_req_q, fetch_req_d;
  logic          proc_valid_q, proc_valid_d;
  logic          wr_en_q, wr_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          abort_w;

`ifdef CELL_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      opc_q        <= '0;
      usr_q        <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
      fetch_req_q  <= 1'b0;
      proc_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      opc_q        <= opc_d;
      usr_q        <= usr_d;
      data_q       <= data_d;
      err_q        <= err_d;
      fetch_req_q  <= fetch_req_d;
      proc_valid_q <= proc_valid_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    opc_d   = opc_q;
    usr_d   = usr_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start) begin
        opc_d  = opcode_in;
        usr_d  = user_in;
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
        err_d  = (opcode_in > OP_MAX);
        state_d = (opcode_in > OP_MAX) ? S_DONE : S_FETCH;
      end
      S_FETCH: if (fetch_ack)  state_d = S_ISSUE;
      S_ISSUE: if (proc_ready) state_d = S_WAIT;
      S_WAIT: if (res_valid) begin
        data_d  = res_pixel;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        addr_d = addr_q + AW'(1);
        if (x_q == X_LAST) begin
          x_d     = '0;
          y_d     = y_q + YW'(1);
          state_d = (y_q == Y_LAST) ? S_DONE : S_FETCH;
        end else begin
          x_d     = x_q + XW'(1);
          state_d = S_FETCH;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort_w && state_q != S_IDLE) state_d = S_IDLE;
  end

  // Strobes are flopped from the next state so each is a clean register output.
  always_comb begin
    fetch_req_d  = (state_d == S_FETCH);
    proc_valid_d = (state_d == S_ISSUE);
    wr_en_d      = (state_d == S_WRITE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign fetch_req   = fetch_req_q;
  assign fetch_x     = x_q;
  assign fetch_y     = y_q;
  assign proc_valid  = proc_valid_q;
  assign proc_opcode = opc_q;
  assign proc_user   = usr_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = addr_q;
  assign wr_data     = data_q;

endmodule

// File: tb/tb_cell_scan_sequencer.sv
// Directed bench for cell_scan_sequencer on a 5x4 image with 3x3 cells (3x2 outputs).
module tb_cell_scan_sequencer;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  opcode_in;
  logic [7:0]  user_in;
  logic        busy, done, err, fetch_req, proc_valid, wr_en;
  logic [2:0]  fetch_x;
  logic [1:0]  fetch_y;
  logic        fetch_ack, proc_ready, res_valid;
  logic [3:0]  proc_opcode;
  logic [7:0]  proc_user;
  logic [23:0] res_pixel, wr_data;
  logic [2:0]  wr_addr;
`ifdef CELL_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif

  logic        rdy_en = 1'b1, res_en = 1'b1, res_force = 1'b0, res_ovr_en = 1'b0;
  logic [23:0] res_ovr = '0;
  int          nproc = 0;
  int          vec = 0, miss = 0;
  int          rd_w = 0, rd_f = 0;

  logic [2:0]  wa_q[$];
  logic [23:0] wd_q[$];
  logic [2:0]  fx_q[$];
  logic [1:0]  fy_q[$];
  int          exp_addr[$], exp_fx[$], exp_fy[$];
  logic [23:0] exp_data[$];

  always #5 clk = ~clk;

  function automatic logic [23:0] pix_of(input int n);
    return 24'h100000 + 24'(n) * 24'h010101;
  endfunction

  assign fetch_ack  = 1'b1;
  assign proc_ready = rdy_en;
  assign res_valid  = res_force | res_en;
  assign res_pixel  = res_ovr_en ? res_ovr : pix_of(nproc);

  cell_scan_sequencer #(.IMG_W(5), .IMG_H(4), .CELL_N(3)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode_in(opcode_in), .user_in(user_in),
`ifdef CELL_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .err(err),
    .fetch_req(fetch_req), .fetch_x(fetch_x), .fetch_y(fetch_y), .fetch_ack(fetch_ack),
    .proc_valid(proc_valid), .proc_ready(proc_ready), .proc_opcode(proc_opcode), .proc_user(proc_user),
    .res_valid(res_valid), .res_pixel(res_pixel),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  // Result pixel seen in WAIT is a function of how many operations have been accepted.
  always @(posedge clk) if (proc_valid && proc_ready) nproc <= nproc + 1;

  always @(negedge clk) begin
    if (wr_en) begin wa_q.push_back(wr_addr); wd_q.push_back(wr_data); end
    if (fetch_req && fetch_ack) begin fx_q.push_back(fetch_x); fy_q.push_back(fetch_y); end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vec++;
    assert (obs === expv) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_strobes"}, {busy, done, err, fetch_req, proc_valid, wr_en}, 0);
    chk({tag, "_coords"},  {fetch_x, fetch_y, wr_addr}, 0);
    chk({tag, "_data"},    {wr_data, proc_opcode, proc_user}, 0);
  endtask

  task automatic start_job(input logic [3:0] op, input logic [7:0] usr, input bit push_exp);
    if (push_exp)
      for (int k = 0; k < 6; k++) begin
        exp_addr.push_back(k);
        exp_data.push_back(pix_of(nproc + k + 1));
        exp_fx.push_back(k % 3);
        exp_fy.push_back(k / 3);
      end
    @(posedge clk); #1;
    start = 1'b1; opcode_in = op; user_in = usr;
    @(posedge clk); #1;
    start = 1'b0; opcode_in = 4'hF; user_in = 8'hEE;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!done && cyc < 200);
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic check_job(input int nw, input int nf);
    int aw, af;
    aw = wa_q.size() - rd_w;
    af = fx_q.size() - rd_f;
    chk("wr_count", aw, nw);
    chk("fetch_count", af, nf);
    for (int k = 0; k < nw && k < aw && exp_addr.size() > 0; k++) begin
      chk("wr_addr", wa_q[rd_w + k], exp_addr.pop_front());
      chk("wr_data", wd_q[rd_w + k], exp_data.pop_front());
    end
    for (int k = 0; k < nf && k < af && exp_fx.size() > 0; k++) begin
      chk("fetch_x", fx_q[rd_f + k], exp_fx.pop_front());
      chk("fetch_y", fy_q[rd_f + k], exp_fy.pop_front());
    end
    rd_w = wa_q.size(); rd_f = fx_q.size();
    exp_addr.delete(); exp_data.delete(); exp_fx.delete(); exp_fy.delete();
  endtask

  initial begin
    int cyc, n;
    reset = 1'b1; start = 1'b0; opcode_in = '0; user_in = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // Plain job, all handshakes immediate
    start_job(4'd0, 8'h5A, 1);
    @(negedge clk);
    chk("s1_fetch0", {fetch_req, busy, proc_valid, wr_en}, 4'b1100);
    chk("s1_user", {proc_opcode, proc_user}, 12'h05A);
    wait_done(cyc);
    chk("s1_done_latency", cyc, 24);
    @(negedge clk);
    chk("s1_idle_after", {busy, done, err}, 0);
    check_job(6, 6);

    // Stall proc_ready for 5 cycles on the third cell
    start_job(4'd7, 8'hC3, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!(fetch_req && fetch_x == 3'd2 && fetch_y == 2'd0) && n < 100);
    chk("s2_reach_cell2", fetch_req, 1);
    rdy_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s2_stall_hold", {proc_valid, proc_opcode, proc_user}, {1'b1, 4'd7, 8'hC3});
    end
    rdy_en = 1'b1;
    wait_done(cyc);
    check_job(6, 6);

    // Illegal opcode, then a legal one clears err
    start_job(4'd13, 8'h01, 0);
    @(negedge clk);
    chk("s3_err_done", {err, done, busy, fetch_req, wr_en}, 5'b11100);
    @(negedge clk);
    chk("s3_after", {err, done, busy}, 3'b100);
    check_job(0, 0);
    start_job(4'd11, 8'h3C, 1);
    @(negedge clk);
    chk("s3_err_clear", {err, fetch_req, proc_opcode}, {1'b0, 1'b1, 4'd11});
    wait_done(cyc);
    check_job(6, 6);

    // Stray res_valid in FETCH; real capture in WAIT
    res_en = 1'b0;
    start_job(4'd5, 8'h42, 1);
    exp_data[0] = 24'hA5B6C7;
    @(negedge clk);
    res_ovr_en = 1'b1; res_ovr = 24'h111111; res_force = 1'b1;
    @(negedge clk);
    res_force = 1'b0; res_ovr = 24'hA5B6C7;
    chk("s4_issue", proc_valid, 1);
    @(negedge clk);
    chk("s4_wait0", {fetch_req, proc_valid, wr_en}, 0);
    @(negedge clk);
    chk("s4_wait1", {fetch_req, proc_valid, wr_en}, 0);
    res_force = 1'b1;
    @(negedge clk);
    chk("s4_write", {wr_en, wr_data}, {1'b1, 24'hA5B6C7});
    res_force = 1'b0; res_ovr_en = 1'b0; res_en = 1'b1;
    wait_done(cyc);
    check_job(6, 6);

    // Reset after the third write, then restart
    start_job(4'd2, 8'h77, 1);
    n = 0; cyc = 0;
    do begin @(negedge clk); cyc++; if (wr_en) n++; end while (n < 3 && cyc < 100);
    chk("s5_three_writes", n, 3);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("s5_reset");
    reset = 1'b0;
    check_job(3, 3);
    start_job(4'd1, 8'h99, 1);
    @(negedge clk);
    chk("s5_restart", {fetch_req, fetch_x, fetch_y, wr_addr}, {1'b1, 3'd0, 2'd0, 3'd0});
    wait_done(cyc);
    check_job(6, 6);

`ifdef CELL_SEQ_ABORT_EN
    // Abort while waiting on the fourth cell
    start_job(4'd3, 8'h11, 1);
    n = 0; cyc = 0;
    do begin @(negedge clk); cyc++; if (proc_valid) n++; end while (n < 4 && cyc < 100);
    res_en = 1'b0;
    @(negedge clk);
    chk("s6_in_wait", {busy, proc_valid, wr_en}, 3'b100);
    abort = 1'b1;
    @(negedge clk);
    chk("s6_aborted", {busy, done, wr_en}, 0);
    abort = 1'b0; res_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("s6_quiet", {done, wr_en, fetch_req, busy}, 0);
    end
    check_job(3, 4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/cell_scan_sequencer.md
CELL_SCAN_SEQUENCER -- requirements
Module: cell_scan_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- IMG_W, 640, input image width in pixels.
- IMG_H, 480, input image height in pixels.
- CELL_N, 3, cell edge length in pixels.
- Derived constants: OUT_W = IMG_W-CELL_N+1; OUT_H = IMG_H-CELL_N+1; XW = clog2(IMG_W); YW = clog2(IMG_H); AW = clog2(OUT_W*OUT_H).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  the single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame job.
- opcode_in  in  4  operation code, ADD=0 .. AVG=11.
- user_in  in  8  immediate operand.
- busy  out  1  job in progress.
- done  out  1  one-cycle job-complete pulse.
- err  out  1  sticky illegal-opcode flag.
- fetch_req  out  1  request to load the cell whose top-left corner is (fetch_x, fetch_y).
- fetch_x  out  XW  cell column.
- fetch_y  out  YW  cell row.
- fetch_ack  in  1  cell loaded.
- proc_valid  out  1  operation offered to the cell processor.
- proc_ready  in  1  cell processor accepts the operation.
- proc_opcode  out  4  latched opcode.
- proc_user  out  8  latched immediate.
- res_valid  in  1  result pixel available.
- res_pixel  in  24  result pixel.
- wr_en  out  1  output-image write strobe.
- wr_addr  out  AW  linear output address.
- wr_data  out  24  pixel to write.

Function
REQ-003 States SHALL be IDLE, FETCH, ISSUE, WAIT, WRITE and DONE; reset SHALL enter IDLE.
REQ-004 In IDLE, when start=1, the block SHALL latch opcode_in and user_in, clear x, y and addr to 0, and go to FETCH. If the opcode is greater than 11, it SHALL instead set err and go to DONE.
REQ-005 start SHALL be ignored in every state except IDLE. err SHALL clear on the next accepted start.
REQ-006 In FETCH, fetch_req SHALL be 1 with fetch_x=x and fetch_y=y. fetch_ack=1 in the same cycle SHALL move the FSM to ISSUE.
REQ-007 In ISSUE, proc_valid SHALL be 1. proc_opcode and proc_user SHALL be stable while proc_valid=1. proc_valid=1 with proc_ready=1 SHALL move the FSM to WAIT.
REQ-008 In WAIT, res_valid=1 SHALL capture res_pixel into wr_data and move the FSM to WRITE. res_valid SHALL be ignored in every other state.
REQ-009 In WRITE, wr_en SHALL be 1 for exactly one cycle with wr_addr=addr, where addr = y*OUT_W+x.
- Then addr SHALL increment.
- If x=OUT_W-1: x SHALL wrap to 0 and y SHALL increment; otherwise x SHALL increment.
- If x=OUT_W-1 and y=OUT_H-1, the next state SHALL be DONE; otherwise FETCH.
REQ-010 DONE SHALL assert done for one cycle and return to IDLE.
REQ-011 busy SHALL be 1 in every state except IDLE.
REQ-012 fetch_req, proc_valid and wr_en SHALL be mutually exclusive and registered, with no combinational path from any input.
REQ-013 One cell SHALL be outstanding at a time. Minimum cost SHALL be 4 cycles per output pixel when fetch_ack, proc_ready and res_valid respond immediately.
REQ-014 A job SHALL produce exactly OUT_W*OUT_H writes, at addresses 0 .. OUT_W*OUT_H-1 in strictly increasing order.

Reset
REQ-015 When reset=1 at a clock edge, the block SHALL return to IDLE from any state, abandoning any job.
- busy, done, err, fetch_req, proc_valid and wr_en SHALL be 0.
- fetch_x, fetch_y, wr_addr, wr_data, proc_opcode and proc_user SHALL be 0.
REQ-016 reset SHALL take priority over start in the same cycle.

Configuration
REQ-017 Macro CELL_SEQ_ABORT_EN SHALL control the abort feature.
- Defined: a 1-bit input abort exists. abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge with no done pulse and no further write; abort in IDLE SHALL have no effect.
- Undefined: the port is absent and jobs always run to completion.

Verification
REQ-018 Directed scenarios, all with IMG_W=5, IMG_H=4, CELL_N=3 (OUT_W=3, OUT_H=2):
- start, opcode 0, all handshakes tied high -> 6 writes at addr 0..5; fetch coords (0,0),(1,0),(2,0),(0,1),(1,1),(2,1); done 24 cycles after the FSM enters FETCH; busy low afterwards.
- proc_ready held low for 5 cycles on cell 2 -> proc_valid and proc_opcode stable throughout; still 6 writes in order.
- start with opcode 13 -> err=1, done pulse, no fetch_req or wr_en; a following start with opcode 11 clears err.
- res_valid pulsed while in FETCH -> ignored; wr_data equals res_pixel from the WAIT-state handshake (e.g. 24'hA5B6C7).
- reset asserted after the 3rd write -> all outputs 0 next cycle; a new start restarts at addr 0.
- CELL_SEQ_ABORT_EN defined, abort during WAIT of cell 4 -> IDLE next cycle, no done, exactly 3 writes.
